// File: rtl/jtag_axi_pkg.sv
// Shared definitions for the JTAG-to-AXI debug bridge: FSM states, command word layout,
// AXI response codes and strobe-width helper.
// Pure declarations, no logic.
package jtag_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_t;

    // Command header layout (low byte of the JTAG data register).
    localparam int CMD_REQ      = 0;
    localparam int CMD_WRITE    = 1;
    localparam int CMD_SIZE_LSB = 2;
    localparam int CMD_SIZE_W   = 3;
    localparam int CMD_HDR_W    = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/jtag_axi_strb_gen.sv
// Byte-strobe generator for single-beat AXI writes: strb = ((1 << 2^size) - 1) << offset.
// Latency: purely combinational. Backpressure: none.
// Ports: size (log2 bytes), offset (byte lane of the aligned address), strb (one bit per lane).
module jtag_axi_strb_gen
    import jtag_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [CMD_SIZE_W-1:0]              size,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]    offset,
    output logic [strb_width(DATA_WIDTH)-1:0]  strb
);

    localparam int STRB_W = strb_width(DATA_WIDTH);

    logic [STRB_W-1:0] mask;

    // Build the low-aligned mask lane by lane so a full-width transfer never needs
    // an (STRB_W+1)-bit intermediate.
    always_comb begin
        mask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            mask[i] = (i < (1 << size));
        end
        strb = mask << offset;
    end

endmodule

// File: rtl/jtag_axi_bridge.sv
// JTAG-to-AXI4 single-beat master: captures a command on update_i and issues one read or write.
// Latency: write AW at T+1, W at T+2, B at T+3; read AR at T+1, R at T+2, data visible T+3.
// Backpressure: valids held until ready; update_i while busy is dropped and flags overrun.
// Ports: clk_i/rst_ni; update_i + axireg_i command in; axireg_o status/read data out;
//        full AW/W/B/AR/R AXI4 master channels (IDs 0, len 0, INCR).
// Optional hang detection: define JTAG_AXI_TIMEOUT_EN to build the busy-cycle counter.
module jtag_axi_bridge
    import jtag_axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   update_i,
    input  logic [CMD_HDR_W+ADDR_WIDTH+DATA_WIDTH-1:0] axireg_i,
    output logic [CMD_HDR_W+ADDR_WIDTH+DATA_WIDTH-1:0] axireg_o,
    // AW
    output logic [ID_WIDTH-1:0]                    aw_id_o,
    output logic [ADDR_WIDTH-1:0]                  aw_addr_o,
    output logic [7:0]                             aw_len_o,
    output logic [2:0]                             aw_size_o,
    output logic [1:0]                             aw_burst_o,
    output logic                                   aw_lock_o,
    output logic [3:0]                             aw_cache_o,
    output logic [2:0]                             aw_prot_o,
    output logic [3:0]                             aw_qos_o,
    output logic [3:0]                             aw_region_o,
    output logic                                   aw_valid_o,
    input  logic                                   aw_ready_i,
    // W
    output logic [DATA_WIDTH-1:0]                  w_data_o,
    output logic [DATA_WIDTH/8-1:0]                w_strb_o,
    output logic                                   w_last_o,
    output logic                                   w_valid_o,
    input  logic                                   w_ready_i,
    // B
    input  logic [1:0]                             b_resp_i,
    input  logic                                   b_valid_i,
    output logic                                   b_ready_o,
    // AR
    output logic [ID_WIDTH-1:0]                    ar_id_o,
    output logic [ADDR_WIDTH-1:0]                  ar_addr_o,
    output logic [7:0]                             ar_len_o,
    output logic [2:0]                             ar_size_o,
    output logic [1:0]                             ar_burst_o,
    output logic                                   ar_lock_o,
    output logic [3:0]                             ar_cache_o,
    output logic [2:0]                             ar_prot_o,
    output logic [3:0]                             ar_qos_o,
    output logic [3:0]                             ar_region_o,
    output logic                                   ar_valid_o,
    input  logic                                   ar_ready_i,
    // R
    input  logic [DATA_WIDTH-1:0]                  r_data_i,
    input  logic [1:0]                             r_resp_i,
    input  logic                                   r_last_i,
    input  logic                                   r_valid_i,
    output logic                                   r_ready_o
);

    localparam int CMD_W    = CMD_HDR_W + ADDR_WIDTH + DATA_WIDTH;
    localparam int OFF_W    = $clog2(DATA_WIDTH/8);
    localparam int MAX_SIZE = OFF_W;

    state_t                  state_q;
    logic [CMD_W-1:0]        cmd_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;
    logic                    overrun_q;
    logic                    timeout_q;

    logic                    busy;
    logic                    in_req;
    logic                    in_write;
    logic [CMD_SIZE_W-1:0]   in_size;
    logic                    size_ok;
    logic                    accept;
    logic [CMD_SIZE_W-1:0]   cmd_size;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [ADDR_WIDTH-1:0]   align_addr;

    assign busy     = (state_q != ST_IDLE);
    assign in_req   = axireg_i[CMD_REQ];
    assign in_write = axireg_i[CMD_WRITE];
    assign in_size  = axireg_i[CMD_SIZE_LSB +: CMD_SIZE_W];
    assign size_ok  = (in_size <= 3'(MAX_SIZE));
    // Accepted includes illegal-size commands: they still clear status, just issue nothing.
    assign accept   = update_i && !busy && in_req;

    assign cmd_size   = cmd_q[CMD_SIZE_LSB +: CMD_SIZE_W];
    assign cmd_addr   = cmd_q[CMD_HDR_W +: ADDR_WIDTH];
    assign align_addr = cmd_addr & ~((ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1));

    // AXI outputs decode straight from the registered state, so a valid cannot drop
    // until the FSM sees its ready.
    assign aw_id_o     = '0;
    assign aw_addr_o   = align_addr;
    assign aw_len_o    = 8'd0;
    assign aw_size_o   = cmd_size;
    assign aw_burst_o  = BURST_INCR;
    assign aw_lock_o   = 1'b0;
    assign aw_cache_o  = 4'd0;
    assign aw_prot_o   = 3'd0;
    assign aw_qos_o    = 4'd0;
    assign aw_region_o = 4'd0;
    assign aw_valid_o  = (state_q == ST_AW);

    assign w_data_o    = cmd_q[CMD_HDR_W+ADDR_WIDTH +: DATA_WIDTH];
    assign w_valid_o   = (state_q == ST_W);
    assign w_last_o    = w_valid_o;
    assign b_ready_o   = (state_q == ST_B);

    assign ar_id_o     = '0;
    assign ar_addr_o   = align_addr;
    assign ar_len_o    = 8'd0;
    assign ar_size_o   = cmd_size;
    assign ar_burst_o  = BURST_INCR;
    assign ar_lock_o   = 1'b0;
    assign ar_cache_o  = 4'd0;
    assign ar_prot_o   = 3'd0;
    assign ar_qos_o    = 4'd0;
    assign ar_region_o = 4'd0;
    assign ar_valid_o  = (state_q == ST_AR);
    assign r_ready_o   = (state_q == ST_R);

    jtag_axi_strb_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_gen (
        .size   (cmd_size),
        .offset (align_addr[OFF_W-1:0]),
        .strb   (w_strb_o)
    );

    assign axireg_o = {rdata_q, {ADDR_WIDTH{1'b0}}, 3'b000, overrun_q, timeout_q, busy, resp_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q     <= axireg_i;
                        overrun_q <= 1'b0;
                        if (size_ok) begin
                            resp_q  <= RESP_OKAY;
                            state_q <= in_write ? ST_AW : ST_AR;
                        end else begin
                            resp_q  <= RESP_SLVERR;
                        end
                    end
                end
                ST_AR: if (ar_ready_i) state_q <= ST_R;
                ST_R: begin
                    if (r_valid_i) begin
                        rdata_q <= r_data_i;
                        resp_q  <= r_resp_i;
                        state_q <= ST_IDLE;
                    end
                end
                ST_AW: if (aw_ready_i) state_q <= ST_W;
                ST_W:  if (w_ready_i)  state_q <= ST_B;
                ST_B: begin
                    if (b_valid_i) begin
                        resp_q  <= b_resp_i;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (update_i && busy) overrun_q <= 1'b1;
        end
    end

`ifdef JTAG_AXI_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TCNT_W-1:0] tcnt_q;

    // Counter parks at the limit; the FSM keeps waiting so the bus stays protocol-safe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else if (busy) begin
            if (tcnt_q != TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                tcnt_q <= tcnt_q + 1'b1;
            end else begin
                timeout_q <= 1'b1;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{r_last_i, cmd_q[CMD_HDR_W-1:CMD_SIZE_LSB+CMD_SIZE_W], cmd_q[CMD_WRITE:CMD_REQ]};
`else
    assign timeout_q = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{r_last_i, cmd_q[CMD_HDR_W-1:CMD_SIZE_LSB+CMD_SIZE_W], cmd_q[CMD_WRITE:CMD_REQ],
                         (TIMEOUT_CYCLES > 0)};
`endif

endmodule

// File: doc/jtag_axi_bridge.md
# jtag_axi_bridge

Parametrised JTAG-to-AXI4 single-beat master, the next-generation debug access bridge. It captures a command/address/data word from the JTAG data register on an update pulse and issues one AXI4 read or write. Added behaviour: sub-word transfers with generated byte strobes, a response/status report, overrun detection, and an optional hang-detection timeout. It sits between the JTAG TAP data-register chain (already in the clk_i domain) and the SoC AXI crossbar.

## Interface
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 64: AXI data width, power of two, 32..512.
- ID_WIDTH, 4: AXI ID width; all IDs driven 0.
- TIMEOUT_CYCLES, 1024: hang-detect limit, used only with the timeout feature.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- update_i  in  1  single-cycle pulse; the JTAG register holds a new command.
- axireg_i  in  8+ADDR_WIDTH+DATA_WIDTH  bits [0] req, [1] write, [4:2] size (log2 bytes), [7:5] reserved, then address, then write data.
- axireg_o  out  8+ADDR_WIDTH+DATA_WIDTH  bits [1:0] resp, [2] busy, [3] timeout, [4] overrun, [7:5] 0, then zero address field, then read data.
- aw_id/addr/len/size/burst/valid_o, aw_ready_i: AW channel. len is 0, burst is INCR, prot/cache/lock/qos/region/user are 0.
- w_data/strb/last/valid_o, w_ready_i: W channel. last is 1 whenever valid is 1.
- b_resp_i, b_valid_i, b_ready_o: B channel.
- ar_id/addr/len/size/burst/valid_o, ar_ready_i: AR channel, with the same constants as AW.
- r_data_i, r_resp_i, r_last_i, r_valid_i, r_ready_o: R channel.

## Operation
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE + update_i with req=1:
  - Latch the full command word into cmd_q.
  - Clear resp, timeout and overrun.
  - Go to AW if write=1, else AR.
- IDLE + update_i with req=0: no operation. State and status are unchanged.
- Illegal size (size > log2(DATA_WIDTH/8)): no bus traffic. resp is set to 2'b10 and the FSM stays in IDLE.
- Address driven: cmd_q address aligned down to 2^size bytes. aw_size/ar_size = size.
- AR: ar_valid_o=1 until ar_ready_i, then go to R.
- R: r_ready_o=1. On r_valid_i, capture r_data_i and r_resp_i, then go to IDLE. r_last_i is ignored because len=0.
- AW: aw_valid_o=1 until aw_ready_i, then go to W.
- W: w_valid_o=1 until w_ready_i, then go to B.
  - w_data is the cmd_q data unchanged; the caller places the data in the correct lanes.
  - w_strb = ((1<<2^size)-1) << (aligned address mod DATA_WIDTH/8).
- B: b_ready_o=1. On b_valid_i, capture b_resp_i and go to IDLE.
- busy = (state != IDLE).
- update_i while busy: the command is ignored and overrun is set, sticky until the next accepted command.
- Once asserted, a valid is never dropped before its ready (AXI-compliant). AXI inputs are ignored in states that do not use them.
- Read data holds its value until the next completed read. It is not cleared by writes.

## Timing
- Reset values:
  - All valid/ready outputs 0.
  - State IDLE.
  - cmd_q, read data, resp, timeout and overrun all 0.
  - axireg_o all 0.
- Bus outputs are decoded combinationally from state and cmd_q. Command capture is registered.
- Latency with ready always high:
  - Write: update at cycle T, aw_valid at T+1, w_valid at T+2, b_ready at T+3, busy low at T+4 when b_valid is present at T+3.
  - Read: ar_valid at T+1, r_ready at T+2, data visible on axireg_o at T+3.
- A response arriving in the same cycle as the state is entered is accepted in that cycle.
- Reset mid-transaction aborts immediately to IDLE. The system resets the interconnect alongside.

## Configuration
- JTAG_AXI_TIMEOUT_EN defined:
  - A counter clears on command acceptance and increments every busy cycle.
  - Reaching TIMEOUT_CYCLES-1 sets the sticky timeout bit.
  - The FSM keeps waiting, which stays protocol-safe.
- Undefined: no counter is built and timeout reads 0.

## Structure
- Package jtag_axi_pkg: state enum, command field offsets, resp encodings (OKAY, EXOKAY, SLVERR, DECERR), strobe width constant.
- Sub-module jtag_axi_strb_gen: size and address offset in, w_strb out. Purely combinational; reused by other debug masters.

## Test plan
- Write 0x1122334455667788 to 0x1000, size 3, ready always 1 -> AW addr 0x1000, w_strb 0xFF, busy low at T+4, resp 00.
- Read 0x2004, size 2, slave returns 0xDEADBEEF_CAFEF00D with SLVERR -> ar_addr 0x2004, axireg_o data 0xDEADBEEF_CAFEF00D, resp 10.
- Write size 1 to 0x3006 -> w_strb 0xC0. Write size 0 to 0x3003 -> w_strb 0x08.
- Slave stalls aw_ready for 50 cycles; a second update at cycle 10 -> aw_valid held stable throughout, overrun=1, second command never issued.
- JTAG_AXI_TIMEOUT_EN with TIMEOUT_CYCLES=16, b_valid withheld -> timeout=1 after 16 busy cycles, b_ready stays 1. Late b_valid completes the write with busy low.
- Size 4 with DATA_WIDTH=64 -> no AXI valid ever asserted, resp 10. Then rst_ni pulsed mid-read -> all outputs back to reset values.
